tlb_maint_ctrl: RTL and testbench

Multi-cycle controller that owns the TLB write port and sequences all TLB maintenance writes (TLBWR, TLBFILL, INVTLB) issued from the write-back stage. TLBWR/TLBFILL are single writes. INVTLB is a 16-entry sweep over the TLB read port that clears the E bit of every matching entry. On completion the block raises a refetch flush so that instructions fetched under stale translations are discarded. It sits between WB (requester) and the TLB array (read port r_*, write port w_*).

---
 rtl/tlb_maint_if.sv | 33 +++
 rtl/tlb_maint_ctrl.sv | 132 +++++++++++++
 tb/tb_tlb_maint_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/tlb_maint_if.sv
// WB-to-controller request handshake plus the TLB array read/write ports.
// req_valid/req_ready: a request transfers on a clock edge where both are high; WB then holds it until done.
interface tlb_maint_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [4:0]  req_inv_op;
  logic [9:0]  req_asid;
  logic [18:0] req_vppn;
  logic [3:0]  req_index;
  logic [88:0] req_entry;
  logic        req_refill;
  logic        req_ready;
  logic [3:0]  r_index;
  logic [88:0] r_entry;
  logic        we;
  logic [3:0]  w_index;
  logic [88:0] w_entry;
  logic        done;
  logic        inv_err;
  logic        flush_req;

  modport slave (
    input  req_valid, req_op, req_inv_op, req_asid, req_vppn, req_index,
           req_entry, req_refill, r_entry,
    output req_ready, r_index, we, w_index, w_entry, done, inv_err, flush_req
  );

  modport master (
    output req_valid, req_op, req_inv_op, req_asid, req_vppn, req_index,
           req_entry, req_refill, r_entry,
    input  req_ready, r_index, we, w_index, w_entry, done, inv_err, flush_req
  );
endinterface

// File: rtl/tlb_maint_ctrl.sv
// Sequences TLBWR/TLBFILL single writes and the 16-entry INVTLB sweep, then
// pulses done/flush_req so WB refetches under the new translations.
module tlb_maint_ctrl (
  input  logic            clk,
  input  logic            resetn,
  tlb_maint_if.slave      bus,
  output logic [1:0]      dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, SWEEP = 2'd2, DONE = 2'd3} state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [4:0]  inv_op_q;
  logic [9:0]  asid_q;
  logic [18:0] vppn_q;
  logic [3:0]  index_q;
  logic [88:0] entry_q;
  logic        refill_q;
  logic        inv_err_q;
  logic [3:0]  fill_cnt;
  logic [3:0]  sweep_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      op_q      <= '0;
      inv_op_q  <= '0;
      asid_q    <= '0;
      vppn_q    <= '0;
      index_q   <= '0;
      entry_q   <= '0;
      refill_q  <= 1'b0;
      inv_err_q <= 1'b0;
      fill_cnt  <= '0;
      sweep_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          inv_err_q <= 1'b0;
          if (bus.req_valid && bus.req_op != 2'd0) begin
            op_q     <= bus.req_op;
            inv_op_q <= bus.req_inv_op;
            asid_q   <= bus.req_asid;
            vppn_q   <= bus.req_vppn;
            index_q  <= bus.req_index;
            entry_q  <= bus.req_entry;
            refill_q <= bus.req_refill;
            if (bus.req_op == 2'd3) begin
              if (bus.req_inv_op > 5'd6) begin
                state     <= DONE;
                inv_err_q <= 1'b1;
              end else begin
                state     <= SWEEP;
                sweep_cnt <= '0;
              end
            end else begin
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          if (op_q == 2'd2) fill_cnt <= fill_cnt + 4'd1;
          state <= DONE;
        end
        SWEEP: begin
          sweep_cnt <= sweep_cnt + 4'd1;
          if (sweep_cnt == 4'd15) state <= DONE;
        end
        DONE: begin
          state     <= IDLE;
          inv_err_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Field extraction from the read-port entry for the INVTLB match.
  logic [18:0] e_vppn;
  logic [5:0]  e_ps;
  logic [9:0]  e_asid;
  logic        e_g;
  logic        va_hit;
  logic        asid_hit;
  logic        match;

  always_comb begin
    e_vppn   = bus.r_entry[87:69];
    e_ps     = bus.r_entry[68:63];
    e_asid   = bus.r_entry[62:53];
    e_g      = bus.r_entry[52];
    va_hit   = (e_ps == 6'd21) ? (e_vppn[18:9] == vppn_q[18:9]) : (e_vppn == vppn_q);
    asid_hit = (e_asid == asid_q);
    case (inv_op_q)
      5'd0, 5'd1: match = 1'b1;
      5'd2:       match = e_g;
      5'd3:       match = !e_g;
      5'd4:       match = !e_g && asid_hit;
      5'd5:       match = !e_g && asid_hit && va_hit;
      5'd6:       match = (e_g || asid_hit) && va_hit;
      default:    match = 1'b0;
    endcase
  end

  always_comb begin
    bus.we      = 1'b0;
    bus.w_index = '0;
    bus.w_entry = '0;
    bus.r_index = '0;
    case (state)
      WRITE: begin
        bus.we      = 1'b1;
        bus.w_index = (op_q == 2'd2) ? fill_cnt : index_q;
        bus.w_entry = {entry_q[88] | refill_q, entry_q[87:0]};
      end
      SWEEP: begin
        // Read and write share the index; the write lands at the end of the cycle.
        bus.r_index = sweep_cnt;
        bus.we      = bus.r_entry[88] && match;
        bus.w_index = sweep_cnt;
        bus.w_entry = {1'b0, bus.r_entry[87:0]};
      end
      default: ;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.done      = (state == DONE);
  assign bus.flush_req = (state == DONE);
  assign bus.inv_err   = (state == DONE) && inv_err_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Directed bench for tlb_maint_ctrl: write ops, INVTLB sweeps, invalid op and mid-sweep reset.
module tb_tlb_maint_ctrl;
  logic        clk;
  logic        resetn;
  logic [1:0]  dbg_state;
  logic [88:0] mem [16];
  int          total = 0;
  int          bad   = 0;

  tlb_maint_if bus ();

  tlb_maint_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  assign bus.r_entry = mem[bus.r_index];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [88:0] mk_entry(input logic e, input logic [18:0] vppn,
                                           input logic [5:0] ps, input logic [9:0] asid,
                                           input logic g);
    return {e, vppn, ps, asid, g, 20'hABCDE, 2'd1, 2'd2, 1'b1, 1'b1,
            20'h13579, 2'd3, 2'd1, 1'b0, 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [88:0] obs, input logic [88:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] inv_op, input logic [9:0] asid,
                       input logic [18:0] vppn, input logic [3:0] index,
                       input logic [88:0] entry, input logic refill);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_inv_op = inv_op;
    bus.req_asid   = asid;
    bus.req_vppn   = vppn;
    bus.req_index  = index;
    bus.req_entry  = entry;
    bus.req_refill = refill;
    check("accept_ready", 89'(bus.req_ready), 89'(1'b1));
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    logic [88:0] ent;
    logic [88:0] exp_e;
    logic        exp_we;

    resetn         = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_inv_op = '0;
    bus.req_asid   = '0;
    bus.req_vppn   = '0;
    bus.req_index  = '0;
    bus.req_entry  = '0;
    bus.req_refill = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    tick();
    tick();
    resetn = 1'b1;

    // Reset state
    check("rst_ready", 89'(bus.req_ready), 89'(1'b1));
    check("rst_we", 89'(bus.we), 89'(1'b0));
    check("rst_done", 89'(bus.done), 89'(1'b0));
    check("rst_flush", 89'(bus.flush_req), 89'(1'b0));
    check("rst_r_index", 89'(bus.r_index), 89'(4'd0));
    check("rst_state", 89'(dbg_state), 89'(2'd0));

    // Op 0 with valid is ignored
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd0;
    tick();
    bus.req_valid = 1'b0;
    check("op0_ready", 89'(bus.req_ready), 89'(1'b1));
    check("op0_we", 89'(bus.we), 89'(1'b0));

    // TLBWR index 5
    ent = mk_entry(1'b1, 19'h0ABCD, 6'd12, 10'h2A5, 1'b0);
    issue(2'd1, 5'd0, 10'd0, 19'd0, 4'd5, ent, 1'b0);
    check("wr_we", 89'(bus.we), 89'(1'b1));
    check("wr_index", 89'(bus.w_index), 89'(4'd5));
    check("wr_entry", bus.w_entry, ent);
    check("wr_ready_busy", 89'(bus.req_ready), 89'(1'b0));
    tick();
    check("wr_done", 89'(bus.done), 89'(1'b1));
    check("wr_flush", 89'(bus.flush_req), 89'(1'b1));
    check("wr_inv_err", 89'(bus.inv_err), 89'(1'b0));
    check("wr_done_we", 89'(bus.we), 89'(1'b0));
    tick();

    // Three TLBFILL, NE=1 but refill forces e=1
    for (int k = 0; k < 3; k++) begin
      ent = mk_entry(1'b0, 19'(19'h100 + k), 6'd12, 10'(k), 1'b1);
      exp_e = ent;
      exp_e[88] = 1'b1;
      issue(2'd2, 5'd0, 10'd0, 19'd0, 4'd9, ent, 1'b1);
      check("fill_we", 89'(bus.we), 89'(1'b1));
      check("fill_index", 89'(bus.w_index), 89'(k));
      check("fill_entry", bus.w_entry, exp_e);
      tick();
      check("fill_done", 89'(bus.done), 89'(1'b1));
      tick();
    end

    // INVTLB op 0: every valid entry cleared
    for (int i = 0; i < 16; i++) mem[i] = mk_entry(1'b1, 19'(i * 3), 6'd12, 10'(i), i[0]);
    issue(2'd3, 5'd0, 10'd0, 19'd0, 4'd0, '0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check("inv0_r_index", 89'(bus.r_index), 89'(i));
      check("inv0_we", 89'(bus.we), 89'(1'b1));
      check("inv0_w_index", 89'(bus.w_index), 89'(i));
      check("inv0_w_entry", bus.w_entry, mk_entry(1'b0, 19'(i * 3), 6'd12, 10'(i), i[0]));
      tick();
    end
    check("inv0_done", 89'(bus.done), 89'(1'b1));
    check("inv0_flush", 89'(bus.flush_req), 89'(1'b1));
    check("inv0_done_r_index", 89'(bus.r_index), 89'(4'd0));
    tick();

    // INVTLB op 5, asid 3, va 0x12345
    for (int i = 0; i < 16; i++) mem[i] = mk_entry(1'b1, 19'h12345, 6'd12, 10'h055, 1'b0);
    mem[2]  = mk_entry(1'b1, 19'h12345, 6'd12, 10'h003, 1'b0);
    mem[7]  = mk_entry(1'b1, 19'h12345, 6'd12, 10'h003, 1'b1);
    mem[9]  = mk_entry(1'b1, 19'h12345 ^ 19'h0FF, 6'd21, 10'h003, 1'b0);
    mem[11] = mk_entry(1'b1, 19'h12345 ^ 19'h0FF, 6'd12, 10'h003, 1'b0);
    mem[13] = mk_entry(1'b0, 19'h12345, 6'd12, 10'h003, 1'b0);
    issue(2'd3, 5'd5, 10'h003, 19'h12345, 4'd0, '0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      exp_we = (i == 2) || (i == 9);
      check("inv5_we", 89'(bus.we), 89'(exp_we));
      if (i == 2) check("inv5_entry2", bus.w_entry, mk_entry(1'b0, 19'h12345, 6'd12, 10'h003, 1'b0));
      if (i == 9) check("inv5_entry9", bus.w_entry,
                        mk_entry(1'b0, 19'h12345 ^ 19'h0FF, 6'd21, 10'h003, 1'b0));
      tick();
    end
    check("inv5_done", 89'(bus.done), 89'(1'b1));
    tick();

    // INVTLB op 7: immediate done with inv_err
    issue(2'd3, 5'd7, 10'd0, 19'd0, 4'd0, '0, 1'b0);
    check("inv7_we", 89'(bus.we), 89'(1'b0));
    check("inv7_done", 89'(bus.done), 89'(1'b1));
    check("inv7_inv_err", 89'(bus.inv_err), 89'(1'b1));
    check("inv7_flush", 89'(bus.flush_req), 89'(1'b1));
    tick();
    check("inv7_ready", 89'(bus.req_ready), 89'(1'b1));
    check("inv7_err_clear", 89'(bus.inv_err), 89'(1'b0));

    // Reset in the middle of a sweep, then fill counter restarts at 0
    for (int i = 0; i < 16; i++) mem[i] = mk_entry(1'b1, 19'(i), 6'd12, 10'(i), 1'b0);
    issue(2'd3, 5'd0, 10'd0, 19'd0, 4'd0, '0, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    check("rstmid_r_index", 89'(bus.r_index), 89'(4'd8));
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("rstmid_state", 89'(dbg_state), 89'(2'd0));
    check("rstmid_we", 89'(bus.we), 89'(1'b0));
    check("rstmid_ready", 89'(bus.req_ready), 89'(1'b1));
    check("rstmid_done", 89'(bus.done), 89'(1'b0));
    ent = mk_entry(1'b1, 19'h7, 6'd12, 10'h7, 1'b0);
    issue(2'd2, 5'd0, 10'd0, 19'd0, 4'd3, ent, 1'b0);
    check("rstmid_fill_index", 89'(bus.w_index), 89'(4'd0));
    check("rstmid_fill_entry", bus.w_entry, ent);
    tick();
    check("rstmid_fill_done", 89'(bus.done), 89'(1'b1));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
